// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU command interface: opcodes,
// response error codes, initiator state encoding and opcode byte-sequence helpers.
package alu_pkg;

   localparam logic [3:0] OP_ADD_A_B  = 4'd0;
   localparam logic [3:0] OP_SUB_A_B  = 4'd1;
   localparam logic [3:0] OP_SUB_B_A  = 4'd2;
   localparam logic [3:0] OP_MUL_A_B  = 4'd3;
   localparam logic [3:0] OP_DIV_A_B  = 4'd4;
   localparam logic [3:0] OP_DIV_B_A  = 4'd5;
   localparam logic [3:0] OP_INC_A    = 4'd6;
   localparam logic [3:0] OP_INC_B    = 4'd7;
   localparam logic [3:0] OP_CLR_RES  = 4'd8;
   localparam logic [3:0] OP_ACCUM    = 4'd9;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL = 2'd1;
   localparam logic [1:0] ERR_DIV0    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_OP,
      ST_AM,
      ST_AL,
      ST_BM,
      ST_BL,
      ST_WAIT,
      ST_RESP,
      ST_RECOVER
   } cm_state_t;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_ACCUM;
   endfunction

   // Operand A bytes follow the opcode for every legal op except INC_B and CLR_RES.
   function automatic logic needs_a(input logic [3:0] op);
      return op_legal(op) && !(op inside {OP_INC_B, OP_CLR_RES});
   endfunction

   function automatic logic needs_b(input logic [3:0] op);
      return op inside {OP_ADD_A_B, OP_SUB_A_B, OP_SUB_B_A, OP_MUL_A_B,
                        OP_DIV_A_B, OP_DIV_B_A, OP_INC_B};
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return op inside {OP_DIV_A_B, OP_DIV_B_A};
   endfunction

   function automatic logic div_by_zero(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
      return is_div(op) && ((op == OP_DIV_A_B) ? (b == 16'h0000) : (a == 16'h0000));
   endfunction

endpackage

// File: rtl/alu_cmd_timer.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
module alu_cmd_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expired
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/alu_cmd_master.sv
// Initiator for the byte-serial ALU command bus: accepts one request, serializes
// opcode and operands onto ctl/dat, waits for the ALU ready pulse and returns the result.
module alu_cmd_master
   import alu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int TO_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic [7:0]  req_k,
   input  logic [7:0]  req_c,
   output logic        ctl,
   output logic [7:0]  dat,
   output logic [7:0]  k_val,
   output logic [7:0]  c_val,
   input  logic        alu_ready,
   input  logic [31:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic [1:0]  rsp_err
);

   localparam logic [TO_W-1:0] TMR_RELOAD = TO_W'(TIMEOUT_CYC - 1);

   cm_state_t   state_reg;
   logic        req_ready_reg;
   logic        ctl_reg;
   logic [7:0]  dat_reg;
   logic [7:0]  k_reg;
   logic [7:0]  c_reg;
   logic [3:0]  op_reg;
   logic [15:0] a_reg;
   logic [15:0] b_reg;
   logic        rsp_valid_reg;
   logic [31:0] rsp_result_reg;
   logic [1:0]  rsp_err_reg;

   logic tmr_load;
   logic tmr_dec;
   logic tmr_expired;

   // The timer is reloaded in every other state, so WAIT and RECOVER each start
   // with a full TIMEOUT_CYC-cycle window on their first cycle.
   assign tmr_load = !(state_reg inside {ST_WAIT, ST_RECOVER});
   assign tmr_dec  = !tmr_load;

   alu_cmd_timer #(
      .W (TO_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (TMR_RELOAD),
      .dec      (tmr_dec),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         req_ready_reg  <= 1'b1;
         ctl_reg        <= 1'b0;
         dat_reg        <= 8'h00;
         k_reg          <= 8'h00;
         c_reg          <= 8'h00;
         op_reg         <= 4'h0;
         a_reg          <= 16'h0000;
         b_reg          <= 16'h0000;
         rsp_valid_reg  <= 1'b0;
         rsp_result_reg <= 32'h0;
         rsp_err_reg    <= ERR_OK;
      end else begin
         ctl_reg <= 1'b0;
         dat_reg <= 8'h00;
         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready_reg <= 1'b0;
                  op_reg        <= req_op;
                  a_reg         <= req_a;
                  b_reg         <= req_b;
                  k_reg         <= req_k;
                  c_reg         <= req_c;
                  if (!op_legal(req_op)) begin
                     state_reg      <= ST_RESP;
                     rsp_valid_reg  <= 1'b1;
                     rsp_result_reg <= 32'h0;
                     rsp_err_reg    <= ERR_ILLEGAL;
                  end else if (div_by_zero(req_op, req_a, req_b)) begin
                     state_reg      <= ST_RESP;
                     rsp_valid_reg  <= 1'b1;
                     rsp_result_reg <= 32'h0;
                     rsp_err_reg    <= ERR_DIV0;
                  end else begin
                     state_reg <= ST_OP;
                     ctl_reg   <= 1'b1;
                     dat_reg   <= {4'h0, req_op};
                  end
               end
            end
            ST_OP: begin
               if (needs_a(op_reg)) begin
                  state_reg <= ST_AM;
                  dat_reg   <= a_reg[15:8];
               end else if (needs_b(op_reg)) begin
                  state_reg <= ST_BM;
                  dat_reg   <= b_reg[15:8];
               end else begin
                  state_reg <= ST_WAIT;
               end
            end
            ST_AM: begin
               state_reg <= ST_AL;
               dat_reg   <= a_reg[7:0];
            end
            ST_AL: begin
               if (needs_b(op_reg)) begin
                  state_reg <= ST_BM;
                  dat_reg   <= b_reg[15:8];
               end else begin
                  state_reg <= ST_WAIT;
               end
            end
            ST_BM: begin
               state_reg <= ST_BL;
               dat_reg   <= b_reg[7:0];
            end
            ST_BL: begin
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               // A ready pulse on the expiry cycle still counts as success.
               if (alu_ready) begin
                  state_reg      <= ST_RESP;
                  rsp_valid_reg  <= 1'b1;
                  rsp_result_reg <= alu_result;
                  rsp_err_reg    <= ERR_OK;
               end else if (tmr_expired) begin
                  state_reg      <= ST_RESP;
                  rsp_valid_reg  <= 1'b1;
                  rsp_result_reg <= 32'h0;
                  rsp_err_reg    <= ERR_TIMEOUT;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  if (rsp_err_reg == ERR_TIMEOUT) begin
                     state_reg <= ST_RECOVER;
                  end else begin
                     state_reg     <= ST_IDLE;
                     req_ready_reg <= 1'b1;
                  end
               end
            end
            ST_RECOVER: begin
               if (tmr_expired) begin
                  state_reg     <= ST_IDLE;
                  req_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               req_ready_reg <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_reg;
   assign ctl        = ctl_reg;
   assign dat        = dat_reg;
   assign k_val      = k_reg;
   assign c_val      = c_reg;
   assign rsp_valid  = rsp_valid_reg;
   assign rsp_result = rsp_result_reg;
   assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Randomized self-checking bench for alu_cmd_master with a bus-level ALU responder
// and a request-level reference model (expected bytes, result, error and latency).
module tb_alu_cmd_master;

   localparam int TO = 16;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [7:0]  req_k;
   logic [7:0]  req_c;
   logic        ctl;
   logic [7:0]  dat;
   logic [7:0]  k_val;
   logic [7:0]  c_val;
   logic        alu_ready;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_err;

   int checks = 0;
   int errors = 0;

   int          alu_delay = 4;     // <=0 means the ALU never answers
   logic        inject_ready = 1'b0;
   logic [31:0] ref_acc = 32'h0;

   alu_cmd_master #(
      .TIMEOUT_CYC (TO),
      .TO_W        (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_k      (req_k),
      .req_c      (req_c),
      .ctl        (ctl),
      .dat        (dat),
      .k_val      (k_val),
      .c_val      (c_val),
      .alu_ready  (alu_ready),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ALU arithmetic: f(a,b)*k + c; CLR_RES zeroes the accumulator, ACCUM adds a*k+c.
   function automatic logic [31:0] alu_math(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [7:0] k,
                                            input logic [7:0] c, input logic [31:0] acc);
      logic [31:0] base;
      case (op)
         4'd0:    base = 32'(a) + 32'(b);
         4'd1:    base = 32'(a) - 32'(b);
         4'd2:    base = 32'(b) - 32'(a);
         4'd3:    base = 32'(a) * 32'(b);
         4'd4:    base = (b == 0) ? 32'h0 : 32'(a / b);
         4'd5:    base = (a == 0) ? 32'h0 : 32'(b / a);
         4'd6:    base = 32'(a) + 32'd1;
         4'd7:    base = 32'(b) + 32'd1;
         4'd8:    return 32'h0;
         default: return acc + 32'(a) * 32'(k) + 32'(c);
      endcase
      return base * 32'(k) + 32'(c);
   endfunction

   // Bus-level ALU model: decodes ctl/dat bytes and pulses alu_ready alu_delay cycles after the last byte.
   initial begin : alu_responder
      logic [7:0]  r_bytes[$];
      logic [3:0]  r_op;
      logic [15:0] r_a;
      logic [15:0] r_b;
      logic [31:0] r_acc;
      int          r_need;
      int          cd;
      bit          collecting;
      r_op = 4'h0; r_need = 0; cd = 0; collecting = 0; r_acc = 32'h0;
      alu_ready  = 1'b0;
      alu_result = 32'h0;
      forever begin
         @(negedge clk);
         alu_ready = 1'b0;
         if (rst) begin
            collecting = 0;
            cd = 0;
         end else begin
            if (inject_ready) alu_ready = 1'b1;
            if (ctl) begin
               r_op = dat[3:0];
               r_bytes.delete();
               r_need = ((r_op inside {[0:6], 9}) ? 2 : 0) + ((r_op inside {[0:5], 7}) ? 2 : 0);
               collecting = (r_need != 0);
               if (r_need == 0) cd = alu_delay;
            end else if (collecting) begin
               r_bytes.push_back(dat);
               if (r_bytes.size() == r_need) begin
                  collecting = 0;
                  cd = alu_delay;
               end
            end else if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  r_a = 16'h0;
                  r_b = 16'h0;
                  if (r_op inside {[0:6], 9}) begin
                     r_a = {r_bytes[0], r_bytes[1]};
                     if (r_need == 4) r_b = {r_bytes[2], r_bytes[3]};
                  end else if (r_need == 2) begin
                     r_b = {r_bytes[0], r_bytes[1]};
                  end
                  alu_result = alu_math(r_op, r_a, r_b, k_val, c_val, r_acc);
                  if (r_op == 4'd8 || r_op == 4'd9) r_acc = alu_result;
                  alu_ready = 1'b1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (req_ready) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) check("req_ready_timeout", 32'(req_ready), 32'd1);
   endtask

   task automatic do_txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] k, input logic [7:0] c, input int dly, input int stall);
      logic [7:0]  exp_bytes[$];
      logic [1:0]  exp_err;
      logic [31:0] exp_res;
      int          exp_idx;
      int          got_idx;
      bit          prev_rdy;
      bit          ok;

      if (op > 4'd9)                                      exp_err = 2'd1;
      else if ((op == 4'd4 && b == 0) || (op == 4'd5 && a == 0)) exp_err = 2'd2;
      else if (dly <= 0)                                  exp_err = 2'd3;
      else                                                exp_err = 2'd0;

      if (exp_err == 2'd1 || exp_err == 2'd2) begin
         exp_idx = 0;
      end else begin
         exp_bytes.push_back({4'h0, op});
         if (op inside {[0:6], 9}) begin
            exp_bytes.push_back(a[15:8]);
            exp_bytes.push_back(a[7:0]);
         end
         if (op inside {[0:5], 7}) begin
            exp_bytes.push_back(b[15:8]);
            exp_bytes.push_back(b[7:0]);
         end
         exp_idx = exp_bytes.size() - 1 + ((exp_err == 2'd3) ? TO : dly) + 1;
      end
      exp_res = 32'h0;
      if (exp_err == 2'd0) begin
         exp_res = alu_math(op, a, b, k, c, ref_acc);
         if (op == 4'd8 || op == 4'd9) ref_acc = exp_res;
      end

      alu_delay = dly;
      rsp_ready = 1'b0;
      wait_ready(ok);
      if (!ok) return;
      req_op = op; req_a = a; req_b = b; req_k = k; req_c = c;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;

      got_idx  = -1;
      prev_rdy = 0;
      for (int i = 0; i < 200; i++) begin
         if (i == 0) begin
            check("k_val", 32'(k_val), 32'(k));
            check("c_val", 32'(c_val), 32'(c));
         end
         if (rsp_valid) begin
            got_idx = i;
            break;
         end
         if (i < exp_bytes.size()) begin
            check("ctl", 32'(ctl), 32'(i == 0));
            check("dat", 32'(dat), 32'(exp_bytes[i]));
         end else begin
            check("ctl_idle", 32'(ctl), 32'd0);
         end
         prev_rdy = alu_ready;
         tick();
      end
      check("latency", 32'(got_idx), 32'(exp_idx));
      if (got_idx < 0) return;
      if (exp_err == 2'd0) check("rsp_after_ready", 32'(prev_rdy), 32'd1);
      check("rsp_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_result", rsp_result, exp_res);
      $display("txn op=%0d a=%04h b=%04h k=%02h c=%02h -> result=%08h err=%0d lat=%0d",
               op, a, b, k, c, rsp_result, rsp_err, got_idx);

      for (int s = 0; s < stall; s++) begin
         tick();
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_result", rsp_result, exp_res);
         check("stall_err", 32'(rsp_err), 32'(exp_err));
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_drop", 32'(rsp_valid), 32'd0);

      if (exp_err == 2'd3) begin
         for (int j = 1; j <= TO + 1; j++) begin
            inject_ready = (j == 4);
            check("recover_ready", 32'(req_ready), 32'(j > TO));
            check("recover_no_rsp", 32'(rsp_valid), 32'd0);
            if (j <= TO) tick();
         end
         inject_ready = 1'b0;
      end
   endtask

   initial begin : stim
      bit          ok;
      bit          seen;
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      int          dly;
      rst = 1'b1;
      req_valid = 1'b0;
      req_op = 4'h0; req_a = 16'h0; req_b = 16'h0; req_k = 8'h0; req_c = 8'h0;
      rsp_ready = 1'b0;
      repeat (3) tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_ctl", 32'(ctl), 32'd0);
      check("rst_dat", 32'(dat), 32'd0);
      check("rst_k_val", 32'(k_val), 32'd0);
      check("rst_c_val", 32'(c_val), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;
      tick();

      do_txn(4'd0, 16'd3, 16'd5, 8'd2, 8'd1, 4, 0);           // ADD -> 17
      do_txn(4'd4, 16'd100, 16'd7, 8'd1, 8'd0, 3, 0);         // DIV_A_B -> 14
      do_txn(4'd4, 16'd100, 16'd0, 8'd1, 8'd0, 3, 0);         // divide by zero
      do_txn(4'd8, 16'h0, 16'h0, 8'd1, 8'd0, 2, 0);           // CLR_RES -> 0
      do_txn(4'd9, 16'h10, 16'h0, 8'd1, 8'd0, 2, 0);          // ACCUM -> 0x10
      do_txn(4'd9, 16'h10, 16'h0, 8'd1, 8'd0, 5, 0);          // ACCUM -> 0x20
      do_txn(4'hB, 16'h1234, 16'h5678, 8'd1, 8'd0, 2, 0);     // illegal op
      do_txn(4'd7, 16'h0, 16'h00FF, 8'd1, 8'd0, 3, 0);        // INC_B -> 0x100
      do_txn(4'd6, 16'h0005, 16'h0, 8'd1, 8'd0, -1, 0);       // timeout, then RECOVER
      do_txn(4'd1, 16'h0050, 16'h0010, 8'd3, 8'd2, TO, 0);    // ready on the expiry cycle

      // Reset while MUL is driving its B high byte.
      wait_ready(ok);
      if (ok) begin
         req_op = 4'd3; req_a = 16'h1234; req_b = 16'hABCD; req_k = 8'd1; req_c = 8'd0;
         alu_delay = 3;
         req_valid = 1'b1;
         tick();
         req_valid = 1'b0;
         repeat (3) tick();
         check("rst_mid_bm_dat", 32'(dat), 32'hAB);
         rst = 1'b1;
         tick();
         check("rst_mid_ctl", 32'(ctl), 32'd0);
         check("rst_mid_dat", 32'(dat), 32'd0);
         check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
         rst = 1'b0;
         seen = 0;
         repeat (24) begin
            tick();
            if (rsp_valid) seen = 1;
         end
         check("rst_mid_no_rsp", 32'(seen), 32'd0);
      end
      do_txn(4'd0, 16'h0100, 16'h0023, 8'd2, 8'd7, 4, 5);     // post-reset ADD, 5-cycle stall

      for (int n = 0; n < 40; n++) begin
         op  = 4'($urandom_range(0, 11));
         a   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         b   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
         dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TO));
         do_txn(op, a, b, 8'($urandom), 8'($urandom), dly, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
